mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Iterative multiply/divide unit with architectural HI/LO registers. It sits directly downstream of the register file and consumes the two read-port words (`r_data1`, `r_data2`) as operands for MULT/MULTU/DIV/DIVU. It produces HI/LO for MFHI/MFLO. It also accepts MTHI/MTLO writes. The main pipeline stalls on `Busy`.

## Interface
Parameters:
- none. Width is fixed at 32 and iteration count at 32; both are package constants.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- `CLK`  in  1  rising-edge clock.
- `RESET`  in  1  asynchronous, active-high reset.
- `Start`  in  1  begin an operation; sampled at the rising edge of `CLK`.
- `Op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `Src_A`  in  32  multiplicand / dividend (from `r_data1`).
- `Src_B`  in  32  multiplier / divisor (from `r_data2`).
- `HiWrite`  in  1  MTHI write enable.
- `LoWrite`  in  1  MTLO write enable.
- `WData`  in  32  MTHI/MTLO data.
- `Busy`  out  1  operation in flight.
- `Done`  out  1  one-cycle pulse; HI/LO hold the new result.
- `Hi`  out  32  HI register.
- `Lo`  out  32  LO register.

## Operation
- FSM states and transitions:
  - IDLE: on `Start`, go to CALC.
  - CALC: runs exactly 32 iterations, then goes to FIX.
  - FIX: goes to IDLE.
- Start acceptance:
  - `Start` is accepted only in IDLE.
  - On acceptance, latch `Op`, the operand sign flags, and the absolute values (signed ops) or raw values (unsigned ops).
  - `Start` in CALC or FIX is ignored.
- Multiply:
  - Radix-2 shift-add on a 64-bit product.
  - Signed result is negated in FIX when the operand signs differ.
- Divide:
  - Restoring division, one quotient bit per iteration.
  - Quotient goes to `Lo`, remainder to `Hi`.
  - Signed ops: the quotient is negated if the signs differ; the remainder takes the dividend's sign.
  - 0x80000000 / -1 gives `Lo`=0x80000000, `Hi`=0 (truncation, no trap).
  - Divide by zero (either signedness) forces `Hi`=`Src_A` as latched and `Lo`=0xFFFFFFFF. Latency is unchanged.
- Result writeback: `Hi`/`Lo` update only on the FIX→IDLE edge. Intermediate values are never visible.
- MTHI/MTLO:
  - `HiWrite`/`LoWrite` write `WData` at the next edge, only when in IDLE and `Start` is low.
  - If `Start` and a write are asserted together, `Start` wins and the write is dropped.
  - Writes while `Busy` are dropped; the pipeline must stall them.
- Reset values: `Busy`=0, `Done`=0, `Hi`=0, `Lo`=0, state=IDLE.
- Reset mid-operation: aborts immediately; `Hi`/`Lo` return to 0 with no partial result.

## Timing
- `Start` sampled high at edge k:
  - `Busy`=1 from k+1 through the cycle before edge k+34 (33 cycles).
  - At edge k+34: `Hi`/`Lo` update, `Busy`=0, `Done`=1 for one cycle.
- `Done` and `Busy` are both registered and never high together.
- Back-to-back operations: a `Start` asserted in the `Done` cycle is accepted at that cycle's closing edge.
- `Hi`/`Lo` are direct register outputs; MFHI/MFLO see them with no added latency.
- `Src_A`/`Src_B` need only be valid at the accepting edge.

## Configuration
- `MDU_DIV_EN` defined: full behaviour above.
- `MDU_DIV_EN` undefined (divider logic removed):
  - `Start` with `Op`=DIV/DIVU still sets `Busy`, but the FSM jumps from IDLE straight to FIX.
  - `Hi`/`Lo` are left unchanged; `Done` pulses at edge k+2.
  - MULT/MULTU are unaffected.

## Structure
- Shared package `mdu_pkg` holds:
  - `mdu_op_t` enum (MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU).
  - `mdu_state_t` enum (IDLE, CALC, FIX).
  - `MDU_WIDTH`=32 and `MDU_ITERS`=32.
- One sub-module, `mdu_shift_core`:
  - 64-bit accumulator plus one shift-add / shift-subtract step per cycle, selected by a mul/div flag.
  - FSM, sign handling and HI/LO stay in the top level.

## Test plan
- After reset: MULTU 0xFFFFFFFF × 2 → `Busy` high 33 cycles, then `Hi`=0x00000001, `Lo`=0xFFFFFFFE, `Done` one cycle.
- MULT 0xFFFFFFFF × 2 → `Hi`=0xFFFFFFFF, `Lo`=0xFFFFFFFE.
- DIV −7 / 2 → `Lo`=0xFFFFFFFD, `Hi`=0xFFFFFFFF.
- DIVU 100 / 7 → `Lo`=14, `Hi`=2.
- DIVU 5 / 0 → `Hi`=5, `Lo`=0xFFFFFFFF after 34 cycles.
- DIV 0x80000000 / 0xFFFFFFFF → `Lo`=0x80000000, `Hi`=0.
- MTHI 0x1234 while `Busy` → dropped; MTHI 0x1234 in IDLE → `Hi`=0x1234 next cycle. `Start` re-asserted during `Busy` → ignored, no extra `Done`.
- `RESET` asserted at cycle 10 of MULT → `Busy`, `Done`, `Hi`, `Lo` all 0 immediately. A new MULTU 3 × 4 then gives `Lo`=12, `Hi`=0.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// The optional divider is controlled by the MDU_DIV_EN macro in the files that import this package.
package mdu_pkg;

   localparam int MDU_WIDTH = 32;
   localparam int MDU_ITERS = 32;

   typedef enum logic [1:0] {
      MDU_MULT  = 2'b00,
      MDU_MULTU = 2'b01,
      MDU_DIV   = 2'b10,
      MDU_DIVU  = 2'b11
   } mdu_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } mdu_state_t;

   // Two's-complement negate of an operand-width word.
   function automatic logic [MDU_WIDTH-1:0] mdu_neg(input logic [MDU_WIDTH-1:0] v);
      return ~v + {{(MDU_WIDTH-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/mul_div_unit_shift_core.sv
// Shared 64-bit accumulator datapath for the multiply/divide unit.
// Multiply: acc = {partial, multiplier}; each step adds the multiplicand on
// acc[0] and shifts right.  Divide: acc = {remainder, dividend}; each step
// shifts left and performs one restoring subtract, shifting in a quotient bit.
module mdu_shift_core
   import mdu_pkg::*;
(
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic                     init,
   input  logic                     step,
   input  logic                     is_div,
   input  logic [MDU_WIDTH-1:0]     a,
   input  logic [MDU_WIDTH-1:0]     b,
   output logic [2*MDU_WIDTH-1:0]   acc
);

   logic [2*MDU_WIDTH-1:0] acc_q;
   logic [2*MDU_WIDTH-1:0] acc_nxt;
   logic [MDU_WIDTH-1:0]   b_q;
   logic [MDU_WIDTH:0]     add_sum;
   logic [MDU_WIDTH:0]     rem_sh;
   logic [MDU_WIDTH+1:0]   trial;

   // One shift-add or shift-subtract step from the current accumulator.
   always_comb begin
      add_sum = {1'b0, acc_q[2*MDU_WIDTH-1:MDU_WIDTH]} + {1'b0, b_q};
      rem_sh  = acc_q[2*MDU_WIDTH-1:MDU_WIDTH-1];
      trial   = {1'b0, rem_sh} - {2'b00, b_q};
      acc_nxt = acc_q;
      if (is_div) begin
         if (trial[MDU_WIDTH+1])
            acc_nxt = {rem_sh[MDU_WIDTH-1:0], acc_q[MDU_WIDTH-2:0], 1'b0};
         else
            acc_nxt = {trial[MDU_WIDTH-1:0], acc_q[MDU_WIDTH-2:0], 1'b1};
      end else begin
         if (acc_q[0])
            acc_nxt = {add_sum, acc_q[MDU_WIDTH-1:1]};
         else
            acc_nxt = {1'b0, acc_q[2*MDU_WIDTH-1:1]};
      end
   end

   // Accumulator and second operand: load on init, advance on step.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         acc_q <= '0;
         b_q   <= '0;
      end else if (init) begin
         acc_q <= {{MDU_WIDTH{1'b0}}, a};
         b_q   <= b;
      end else if (step) begin
         acc_q <= acc_nxt;
      end
   end

   assign acc = acc_q;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Configuration macro MDU_DIV_EN: defined keeps the divider; undefined removes
// it, and DIV/DIVU then complete in two cycles leaving HI/LO untouched.
//
// Handshake: Start is sampled on a rising CLK edge and accepted only while the
// FSM is IDLE (the Done cycle is IDLE, so back-to-back issue works). Busy is
// registered and high for the whole operation except the accepting cycle
// itself; Done is a one-cycle registered pulse in the cycle HI/LO first show
// the result. Busy and Done are never high together. MTHI/MTLO writes land
// only in IDLE with Start low; all other writes are dropped.
module mul_div_unit
   import mdu_pkg::*;
(
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic                 Start,
   input  logic [1:0]           Op,
   input  logic [MDU_WIDTH-1:0] Src_A,
   input  logic [MDU_WIDTH-1:0] Src_B,
   input  logic                 HiWrite,
   input  logic                 LoWrite,
   input  logic [MDU_WIDTH-1:0] WData,
   output logic                 Busy,
   output logic                 Done,
   output logic [MDU_WIDTH-1:0] Hi,
   output logic [MDU_WIDTH-1:0] Lo,
   output mdu_state_t           state_dbg
);

   localparam logic [5:0] ITER_LAST = 6'(MDU_ITERS);

   mdu_state_t             state;
   mdu_state_t             state_n;
   logic [5:0]             cnt;
   mdu_op_t                op_q;
   logic                   neg_a_q;
   logic                   neg_b_q;
   logic                   start_ok;
   logic                   signed_op;
   logic [MDU_WIDTH-1:0]   abs_a;
   logic [MDU_WIDTH-1:0]   abs_b;
   logic                   core_step;
   logic                   core_is_div;
   logic [2*MDU_WIDTH-1:0] core_acc;
   logic [2*MDU_WIDTH-1:0] prod_fix;
   logic                   sign_diff;
   logic [MDU_WIDTH-1:0]   res_hi;
   logic [MDU_WIDTH-1:0]   res_lo;
`ifdef MDU_DIV_EN
   logic [MDU_WIDTH-1:0]   a_raw_q;
   logic                   div_zero_q;
`else
   logic                   fix_wait;
`endif

   assign start_ok  = Start && (state == IDLE);
   assign signed_op = ~Op[0];
   assign abs_a     = (signed_op && Src_A[MDU_WIDTH-1]) ? mdu_neg(Src_A) : Src_A;
   assign abs_b     = (signed_op && Src_B[MDU_WIDTH-1]) ? mdu_neg(Src_B) : Src_B;
   assign core_step = (state == CALC) && (cnt != ITER_LAST);
   assign state_dbg = state;
`ifdef MDU_DIV_EN
   assign core_is_div = op_q[1];
`else
   assign core_is_div = 1'b0;
`endif

   mdu_shift_core u_core (
      .CLK    (CLK),
      .RESET  (RESET),
      .init   (start_ok),
      .step   (core_step),
      .is_div (core_is_div),
      .a      (abs_a),
      .b      (abs_b),
      .acc    (core_acc)
   );

   // Next-state logic: IDLE -> CALC (32 steps plus a settle cycle) -> FIX -> IDLE.
   always_comb begin
      state_n = state;
      case (state)
         IDLE: begin
`ifdef MDU_DIV_EN
            if (Start) state_n = CALC;
`else
            if (Start) state_n = Op[1] ? FIX : CALC;
`endif
         end
         CALC: if (cnt == ITER_LAST) state_n = FIX;
         FIX: begin
`ifdef MDU_DIV_EN
            state_n = IDLE;
`else
            if (!fix_wait) state_n = IDLE;
`endif
         end
         default: state_n = IDLE;
      endcase
   end

   // Sign correction of the unsigned core result, plus divide-by-zero override.
   always_comb begin
      sign_diff = ~op_q[0] && (neg_a_q ^ neg_b_q);
      prod_fix  = sign_diff ? (~core_acc + 64'd1) : core_acc;
      res_hi    = prod_fix[2*MDU_WIDTH-1:MDU_WIDTH];
      res_lo    = prod_fix[MDU_WIDTH-1:0];
      if (op_q[1]) begin
`ifdef MDU_DIV_EN
         res_lo = sign_diff ? mdu_neg(core_acc[MDU_WIDTH-1:0]) : core_acc[MDU_WIDTH-1:0];
         res_hi = (~op_q[0] && neg_a_q) ? mdu_neg(core_acc[2*MDU_WIDTH-1:MDU_WIDTH])
                                        : core_acc[2*MDU_WIDTH-1:MDU_WIDTH];
         if (div_zero_q) begin
            res_hi = a_raw_q;
            res_lo = '1;
         end
`else
         res_hi = Hi;
         res_lo = Lo;
`endif
      end
   end

   // FSM, operand capture, status flags and the HI/LO registers.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state   <= IDLE;
         cnt     <= '0;
         op_q    <= MDU_MULT;
         neg_a_q <= 1'b0;
         neg_b_q <= 1'b0;
         Busy    <= 1'b0;
         Done    <= 1'b0;
         Hi      <= '0;
         Lo      <= '0;
`ifdef MDU_DIV_EN
         a_raw_q    <= '0;
         div_zero_q <= 1'b0;
`else
         fix_wait <= 1'b0;
`endif
      end else begin
         state <= state_n;
         Busy  <= (state != IDLE) && (state_n != IDLE);
         Done  <= (state == FIX) && (state_n == IDLE);
         if (state == CALC) cnt <= cnt + 6'd1;
         if (start_ok) begin
            cnt     <= '0;
            op_q    <= mdu_op_t'(Op);
            neg_a_q <= signed_op & Src_A[MDU_WIDTH-1];
            neg_b_q <= signed_op & Src_B[MDU_WIDTH-1];
`ifdef MDU_DIV_EN
            a_raw_q    <= Src_A;
            div_zero_q <= (Src_B == '0);
`else
            fix_wait <= Op[1];
`endif
         end
`ifndef MDU_DIV_EN
         if (state == FIX) fix_wait <= 1'b0;
`endif
         if ((state == FIX) && (state_n == IDLE)) begin
            Hi <= res_hi;
            Lo <= res_lo;
         end else if ((state == IDLE) && !Start) begin
            if (HiWrite) Hi <= WData;
            if (LoWrite) Lo <= WData;
         end
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// Randomised scoreboard bench for mul_div_unit; the reference model follows
// the MDU_DIV_EN build selection.
module tb_mul_div_unit;
   import mdu_pkg::*;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        Start;
   logic [1:0]  Op;
   logic [31:0] Src_A;
   logic [31:0] Src_B;
   logic        HiWrite;
   logic        LoWrite;
   logic [31:0] WData;
   logic        Busy;
   logic        Done;
   logic [31:0] Hi;
   logic [31:0] Lo;
   mdu_state_t  state_dbg;

   mul_div_unit dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .Start     (Start),
      .Op        (Op),
      .Src_A     (Src_A),
      .Src_B     (Src_B),
      .HiWrite   (HiWrite),
      .LoWrite   (LoWrite),
      .WData     (WData),
      .Busy      (Busy),
      .Done      (Done),
      .Hi        (Hi),
      .Lo        (Lo),
      .state_dbg (state_dbg)
   );

   // Clock and cycle counter
   always #5 CLK = ~CLK;

   longint cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [63:0] exp_q[$];
   longint      exp_cyc_q[$];
   int          exp_busy_q[$];
   logic [31:0] mdl_hi;
   logic [31:0] mdl_lo;
   int          busy_cnt = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: {HI, LO} after an operation, from plain arithmetic.
   function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] hi,
                                              input logic [31:0] lo);
      longint          sa, sb, sq, sr;
      longint unsigned ua, ub;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'(a);
      ub = longint'(b);
      case (op)
         2'b00: return 64'(sa * sb);
         2'b01: return 64'(ua * ub);
         default: begin
`ifdef MDU_DIV_EN
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            if (op == 2'b10) begin
               sq = sa / sb;
               sr = sa % sb;
               return {32'(sr), 32'(sq)};
            end
            return {32'(ua % ub), 32'(ua / ub)};
`else
            return {hi, lo};
`endif
         end
      endcase
   endfunction

   // Driver: call at a negedge while the unit is idle (or in its Done cycle).
   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] e;
      int          lat;
      int          bcyc;
      Start = 1'b1;
      Op    = op;
      Src_A = a;
      Src_B = b;
      e      = ref_model(op, a, b, mdl_hi, mdl_lo);
      mdl_hi = e[63:32];
      mdl_lo = e[31:0];
      lat  = 34;
      bcyc = 33;
`ifndef MDU_DIV_EN
      if (op[1]) begin
         lat  = 2;
         bcyc = 1;
      end
`endif
      @(posedge CLK);
      #1;
      exp_q.push_back(e);
      exp_cyc_q.push_back(cyc + longint'(lat));
      exp_busy_q.push_back(bcyc);
      busy_cnt = 0;
      Start = 1'b0;
      Op    = 2'($urandom_range(0, 3));
      Src_A = $urandom;
      Src_B = $urandom;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 80; i++) begin
         @(negedge CLK);
         if (Done) return;
      end
      check("done_timeout", 64'd1, 64'd0);
   endtask

   // Monitor / scoreboard: compares every Done against the expected queue.
   always @(negedge CLK) begin
      if (RESET) begin
         busy_cnt = 0;
      end else begin
         if (Busy) busy_cnt++;
         if (Done) begin
            check("busy_low_at_done", {63'd0, Busy}, 64'd0);
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_done: got Done=1 expected no pending operation (t=%0t)", $time);
            end else begin
               check("result_hi_lo", {Hi, Lo}, exp_q.pop_front());
               check("done_cycle", 64'(cyc), 64'(exp_cyc_q.pop_front()));
               check("busy_cycles", 64'(busy_cnt), 64'(exp_busy_q.pop_front()));
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no end of test expected finish");
      $fatal(1, "watchdog");
   end

   // Stimulus
   initial begin
      logic [1:0]  d_op[6];
      logic [31:0] d_a[6];
      logic [31:0] d_b[6];
      logic [31:0] hold;
      logic [31:0] ra;
      logic [31:0] rb;

      d_op = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b11, 2'b10};
      d_a  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd100, 32'd5, 32'h8000_0000};
      d_b  = '{32'd2, 32'd2, 32'd2, 32'd7, 32'd0, 32'hFFFF_FFFF};

      RESET = 1'b1; Start = 1'b0; Op = 2'b00; Src_A = '0; Src_B = '0;
      HiWrite = 1'b0; LoWrite = 1'b0; WData = '0;
      mdl_hi = '0; mdl_lo = '0;
      repeat (2) @(negedge CLK);
      check("reset_busy", {63'd0, Busy}, 64'd0);
      check("reset_done", {63'd0, Done}, 64'd0);
      check("reset_hi_lo", {Hi, Lo}, 64'd0);
      check("reset_state", 64'(state_dbg), 64'(IDLE));
      RESET = 1'b0;
      @(negedge CLK);

      // Directed vectors, issued back-to-back in each Done cycle
      for (int i = 0; i < 6; i++) begin
         issue(d_op[i], d_a[i], d_b[i]);
         wait_done();
      end

      // MTHI while busy is dropped; Start while busy is ignored
      repeat (2) @(negedge CLK);
      issue(2'b01, 32'd5, 32'd6);
      @(negedge CLK);
      hold = Hi;
      HiWrite = 1'b1; WData = 32'h0000_1234;
      Start = 1'b1; Op = 2'b01; Src_A = 32'd9; Src_B = 32'd9;
      @(negedge CLK);
      check("mthi_busy_dropped", {32'd0, Hi}, {32'd0, hold});
      HiWrite = 1'b0;
      repeat (2) @(negedge CLK);
      Start = 1'b0;
      wait_done();

      // MTHI / MTLO in IDLE take effect at the next edge
      @(negedge CLK);
      HiWrite = 1'b1; WData = 32'h0000_1234;
      @(negedge CLK);
      HiWrite = 1'b0;
      check("mthi_idle", {32'd0, Hi}, 64'h1234);
      mdl_hi = 32'h0000_1234;
      LoWrite = 1'b1; WData = 32'h0000_5678;
      @(negedge CLK);
      LoWrite = 1'b0;
      check("mtlo_idle", {32'd0, Lo}, 64'h5678);
      mdl_lo = 32'h0000_5678;
      repeat (40) @(negedge CLK);

      // Start and MTHI together: Start wins, write dropped
      hold = Hi;
      HiWrite = 1'b1; WData = 32'hDEAD_BEEF;
      issue(2'b01, 32'd2, 32'd3);
      HiWrite = 1'b0;
      @(negedge CLK);
      check("start_beats_mthi", {32'd0, Hi}, {32'd0, hold});
      wait_done();

      // Randomised operations with corner operands and random gaps
      for (int i = 0; i < 24; i++) begin
         case ($urandom_range(0, 5))
            0:       rb = 32'd0;
            1:       rb = 32'hFFFF_FFFF;
            2:       rb = 32'($urandom_range(1, 20));
            default: rb = $urandom;
         endcase
         case ($urandom_range(0, 4))
            0:       ra = 32'h8000_0000;
            1:       ra = 32'd0;
            default: ra = $urandom;
         endcase
         issue(2'($urandom_range(0, 3)), ra, rb);
         wait_done();
         repeat ($urandom_range(0, 2)) @(negedge CLK);
      end

      // Reset mid-operation aborts with no partial result
      @(negedge CLK);
      issue(2'b00, 32'h0001_2345, 32'h0000_0777);
      repeat (9) @(negedge CLK);
      RESET = 1'b1;
      #1;
      check("abort_busy", {63'd0, Busy}, 64'd0);
      check("abort_done", {63'd0, Done}, 64'd0);
      check("abort_hi_lo", {Hi, Lo}, 64'd0);
      exp_q.delete();
      exp_cyc_q.delete();
      exp_busy_q.delete();
      mdl_hi = '0;
      mdl_lo = '0;
      @(negedge CLK);
      RESET = 1'b0;
      @(negedge CLK);
      issue(2'b01, 32'd3, 32'd4);
      wait_done();

      repeat (40) @(negedge CLK);
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
